sub_bytes_iter: RTL and testbench



---
 rtl/sub_bytes_iter.sv | 133 +++++++++++++
 tb/tb_sub_bytes_iter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_iter.sv
// rtl/sub_bytes_iter.sv - iterative AES SubBytes engine, LANES S-boxes per clock
// Work register is substituted in place; out_data is a direct view of it.
module sub_bytes_iter #(
  parameter int LANES  = 4,
  parameter bit INV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          mode;
  logic [7:0]    work     [16];
  logic [3:0]    lane_idx [LANES];
  logic [7:0]    lane_in  [LANES];
  logic [7:0]    lane_out [LANES];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] g;
    g = ginv(a);
    return g ^ {g[6:0], g[7]} ^ {g[5:0], g[7:6]} ^ {g[4:0], g[7:5]} ^ {g[3:0], g[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = 4'(int'(cnt) * LANES + l);
      lane_in[l]  = work[lane_idx[l]];
    end
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      if (INV_EN) begin : g_both
        assign lane_out[l] = mode ? inv_sbox(lane_in[l]) : fwd_sbox(lane_in[l]);
      end else begin : g_fwd
        assign lane_out[l] = fwd_sbox(lane_in[l]);
      end
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < 16; i++) out_data[127-8*i -: 8] = work[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      mode      <= 1'b0;
      for (int i = 0; i < 16; i++) work[i] <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          for (int i = 0; i < 16; i++) work[i] <= in_data[127-8*i -: 8];
          mode     <= in_inv & INV_EN;
          cnt      <= '0;
          state    <= RUN;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        RUN: begin
          for (int l = 0; l < LANES; l++) work[lane_idx[l]] <= lane_out[l];
          if (cnt == CW'(N - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// tb/tb_sub_bytes_iter.sv - bench for sub_bytes_iter over every LANES width plus an INV_EN=0 build
// Six instances share the stimulus; a per-instance countdown model predicts the handshakes.
module tb_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_inv = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] in_data = '0;
  logic [5:0]   in_ready, out_valid, busy;
  logic [127:0] out_data [6];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit run_chk = 1'b0;

  localparam logic [127:0] PLAIN = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] SUBD  = 128'hd42711aee0bf98f1b8b45de51e415230;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar g = 0; g < 6; g++) begin : u
      sub_bytes_iter #(
        .LANES ((g == 5) ? 4 : (1 << g)),
        .INV_EN((g == 5) ? 1'b0 : 1'b1)
      ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready[g]),
        .in_data  (in_data),
        .in_inv   (in_inv),
        .out_valid(out_valid[g]),
        .out_ready(out_ready),
        .out_data (out_data[g]),
        .busy     (busy[g])
      );
    end
  endgenerate

  // Reference tables built by brute-force inverse search plus the affine bit rule
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];
  int  lanes_of [6]  = '{1, 2, 4, 8, 16, 4};
  bit  inv_en_of [6] = '{1, 1, 1, 1, 1, 0};

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11b << (k - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] iv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8] ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ c[i];
      fwd_t[x] = s;
      inv_t[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] d, input bit inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = inv ? inv_t[d[127-8*i -: 8]] : fwd_t[d[127-8*i -: 8]];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: idle -> N passes counting down -> done until out_ready
  bit           m_idle [6] = '{default: 1'b1};
  bit           m_done [6] = '{default: 1'b0};
  int           m_cnt  [6] = '{default: 0};
  logic [127:0] m_res  [6];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 6; g++) begin
        m_idle[g] <= 1'b1;
        m_done[g] <= 1'b0;
        m_cnt[g]  <= 0;
      end
    end else begin
      for (int g = 0; g < 6; g++) begin
        if (m_idle[g] && in_valid) begin
          m_res[g]  <= ref_sub(in_data, in_inv && inv_en_of[g]);
          m_cnt[g]  <= 16 / lanes_of[g];
          m_idle[g] <= 1'b0;
        end else if (m_cnt[g] > 0) begin
          m_cnt[g] <= m_cnt[g] - 1;
          if (m_cnt[g] == 1) m_done[g] <= 1'b1;
        end else if (m_done[g] && out_ready) begin
          m_done[g] <= 1'b0;
          m_idle[g] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && run_chk) begin
      for (int g = 0; g < 6; g++) begin
        chk($sformatf("in_ready[%0d]", g), 128'(in_ready[g]), 128'(m_idle[g]));
        chk($sformatf("out_valid[%0d]", g), 128'(out_valid[g]), 128'(m_done[g]));
        chk($sformatf("busy[%0d]", g), 128'(busy[g]), 128'(!m_idle[g]));
        if (m_done[g]) chk($sformatf("out_data[%0d]", g), out_data[g], m_res[g]);
      end
    end
  end

  logic [127:0] got [6];
  int           lat [6];
  bit           seen [6];
  int           t0;

  task automatic run_block(input logic [127:0] d, input bit inv);
    @(negedge clk); #1;
    in_valid = 1'b1; in_data = d; in_inv = inv;
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    for (int g = 0; g < 6; g++) seen[g] = 1'b0;
    #1;
    in_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int g = 0; g < 6; g++)
        if (out_valid[g] && !seen[g]) begin
          seen[g] = 1'b1;
          got[g]  = out_data[g];
          lat[g]  = cyc - t0;
        end
      #1;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_inv  = 1'($urandom);
    end
    for (int g = 0; g < 6; g++) chk($sformatf("timeout[%0d]", g), 128'(seen[g]), 128'(1));
  endtask

  logic [127:0] blk_a, blk_b;

  initial begin
    build_tables();
    chk("model S(00)", 128'(fwd_t[8'h00]), 128'(8'h63));
    chk("model S(01)", 128'(fwd_t[8'h01]), 128'(8'h7c));
    chk("model S(53)", 128'(fwd_t[8'h53]), 128'(8'hed));
    chk("model InvS(63)", 128'(inv_t[8'h63]), 128'(8'h00));
    chk("model InvS(00)", 128'(inv_t[8'h00]), 128'(8'h52));

    #12;
    for (int g = 0; g < 6; g++) begin
      chk($sformatf("rst in_ready[%0d]", g), 128'(in_ready[g]), 128'(1));
      chk($sformatf("rst out_valid[%0d]", g), 128'(out_valid[g]), 128'(0));
      chk($sformatf("rst busy[%0d]", g), 128'(busy[g]), 128'(0));
      chk($sformatf("rst out_data[%0d]", g), out_data[g], 128'(0));
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    run_chk = 1'b1;

    run_block(PLAIN, 1'b0);
    chk("fwd vec L4 data", got[2], SUBD);
    chk("fwd vec L4 latency", 128'(lat[2]), 128'(4));
    chk("fwd vec noinv data", got[5], SUBD);

    run_block(SUBD, 1'b1);
    chk("inv vec L1 data", got[0], PLAIN);
    chk("inv vec L1 latency", 128'(lat[0]), 128'(16));
    chk("inv vec L16 data", got[4], PLAIN);
    chk("inv vec L16 latency", 128'(lat[4]), 128'(1));

    run_block('0, 1'b0);
    chk("zero fwd L4", got[2], {16{8'h63}});
    run_block('0, 1'b1);
    chk("zero inv ignored", got[5], {16{8'h63}});
    chk("zero inv L1", got[0], {16{8'h52}});

    // Backpressure: a second block is offered the whole time but must wait
    blk_a = {$urandom, $urandom, $urandom, $urandom};
    blk_b = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = blk_a; in_inv = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    in_data = blk_b; in_inv = 1'b1;
    repeat (26) @(negedge clk);
    chk("bp out_valid", 128'(out_valid), 128'(6'h3f));
    chk("bp in_ready", 128'(in_ready), 128'(0));
    chk("bp hold L8", out_data[3], ref_sub(blk_a, 1'b0));
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release in_ready", 128'(in_ready), 128'(6'h3f));
    @(negedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(negedge clk);

    // Random traffic with random backpressure
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #1;
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_inv    = 1'($urandom);
    end
    @(negedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(negedge clk);

    // Asynchronous reset after pass 3 of a block
    #1;
    in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom}; in_inv = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 6; g++) begin
      chk($sformatf("midrst in_ready[%0d]", g), 128'(in_ready[g]), 128'(1));
      chk($sformatf("midrst out_valid[%0d]", g), 128'(out_valid[g]), 128'(0));
      chk($sformatf("midrst out_data[%0d]", g), out_data[g], 128'(0));
    end
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    run_block(PLAIN, 1'b0);
    chk("after rst L2 data", got[1], SUBD);
    chk("after rst L8 data", got[3], SUBD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
